wide_field_rmw_reg: RTL and testbench
=====================================

Name: wide_field_rmw_reg

Overview:
Parametrised wide register (WIDTH bits, may span several 32-bit words) updated through NCH independent field-write channels. Each channel applies a FIELD_W-bit read-modify-write (WRITE/XOR/OR/CLEAR) at a run-time bit offset, so fields may straddle word boundaries.
A registered slice-read port returns pre-update values, giving nonblocking semantics. Sticky status and a saturating update counter support on-device self-checking in poplar regression designs.

Parameters:
WIDTH, 74, register width in bits (>=FIELD_W, any value; not restricted to multiples of 32)
FIELD_W, 32, width of each write/read field
NCH, 2, number of write channels (1..8)
RESET_VAL, 74'h2bcf02356897801abfe, value loaded on reset (WIDTH bits)
OFF_W, $clog2(WIDTH), offset field width (derived; not overridden)
CNT_W, 16, update counter width

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
wr_valid  in  NCH  per-channel write request
wr_mode  in  2*NCH  per channel: 0 WRITE, 1 XOR, 2 OR, 3 CLEAR (and-not)
wr_offset  in  OFF_W*NCH  per-channel LSB position of field
wr_data  in  FIELD_W*NCH  per-channel operand
rd_offset  in  OFF_W  read slice LSB position
rd_data  out  FIELD_W  registered slice read
q  out  WIDTH  current register contents
upd_cnt  out  CNT_W  cycles with >=1 effective write, saturating
overlap_seen  out  1  sticky: two valid channels touched a common bit in one cycle
range_err  out  1  sticky: valid request or read with offset >= WIDTH

Behaviour:
- Reset (rst_n==0 at posedge, takes priority over all inputs, including writes in flight): q=RESET_VAL, rd_data=0, upd_cnt=0, overlap_seen=0, range_err=0.
- Write latency 1: requests sampled at posedge N are visible on q after posedge N.
- Per-channel effect: mask = FIELD_W ones << offset, truncated to WIDTH. Field bits beyond WIDTH-1 are silently dropped. An offset >= WIDTH leaves q unchanged and sets range_err.
- Modes on masked bits only:
  - WRITE: q=d
  - XOR: q^=d
  - OR: q|=d
  - CLEAR: q&=~d
  (d is wr_data shifted to offset.) Unmasked bits are always preserved.
- Multi-channel composition in one cycle: channels are applied sequentially in ascending index to a combinational working copy, starting from the current q. Higher index therefore sees lower-index results, e.g. XOR after WRITE acts on the written value. Exactly one register update per cycle.
- overlap_seen is set when the masks of any two valid, in-range channels intersect in the same cycle.
- upd_cnt increments by 1 per cycle in which any valid, in-range channel exists, even if the data leaves q unchanged. It saturates at all-ones with no wrap.
- Read: rd_data at posedge N = q_before_update[rd_offset +: FIELD_W], i.e. the value prior to same-cycle writes.
  - Bits beyond WIDTH-1 read as 0.
  - rd_offset >= WIDTH returns 0 and sets range_err.
- No valid channels: q holds. rd_data still updates every cycle.

Decomposition:
- Package wide_field_rmw_pkg: mode enum (MODE_WRITE/XOR/OR/CLEAR) and a function field_mask(offset) returning the truncated WIDTH-bit mask.
- Sub-module field_rmw_unit (combinational): one channel's mask/shift/op, taking (cur, mode, offset, data) and producing (next, mask, in_range). The top instantiates NCH copies chained in index order.
- All state is in the top: q, rd_data, counter, sticky flags.

Test Plan:
- Reset then idle 4 cycles -> q=0x2bcf02356897801abfe, upd_cnt=0, flags 0, rd_data (rd_offset=15) = 0xAD12F003.
- ch0 WRITE offset 15 data 0x897abc16 -> next cycle q=0x2bcf02344bd5e0b2bfe, upd_cnt=1. rd_offset=15 in the same cycle -> rd_data=0xAD12F003 (old value).
- From reset, ch0 XOR offset 15 data 0x00000001 -> q=0x2bcf023568978012bfe. Repeating the same XOR restores RESET_VAL, upd_cnt=2.
- ch0 WRITE offset 0 data 0, ch1 WRITE offset 8 data 0xFFFFFFFF, same cycle -> q[7:0]=0, q[39:8]=all ones, q[73:40] unchanged, overlap_seen=1.
- ch0 WRITE offset 60 data 0xFFFFFFFF -> q[73:60]=14'h3fff, lower bits unchanged, range_err=0. Then offset 80 -> q unchanged, range_err=1, upd_cnt unchanged.
- rst_n low in the same cycle as a valid ch0 WRITE -> q=RESET_VAL, upd_cnt=0, sticky flags cleared. With CNT_W=2, 5 update cycles -> upd_cnt holds at 3.

Source files
------------

// File: rtl/wide_field_rmw_pkg.sv
// Shared types and helpers for the wide field read-modify-write register.
// The field mask is built at a fixed maximum width; callers truncate it to their own width.
package wide_field_rmw_pkg;

    typedef enum logic [1:0] {
        MODE_WRITE = 2'd0,
        MODE_XOR   = 2'd1,
        MODE_OR    = 2'd2,
        MODE_CLEAR = 2'd3
    } mode_t;

    // Upper bound on WIDTH + FIELD_W for any instance using field_mask.
    localparam int MASK_MAX = 1024;

    function automatic logic [MASK_MAX-1:0] field_mask(
        input int unsigned offset,
        input int unsigned width,
        input int unsigned field_w
    );
        logic [MASK_MAX-1:0] ones;
        logic [MASK_MAX-1:0] limit;
        ones  = (MASK_MAX'(1) << field_w) - MASK_MAX'(1);
        limit = (MASK_MAX'(1) << width) - MASK_MAX'(1);
        return (ones << offset) & limit;
    endfunction

endpackage

// File: rtl/field_rmw_unit.sv
// One channel of field update: builds the shifted mask/operand and applies the mode to cur.
// Purely combinational; the caller decides whether the result is used.
module field_rmw_unit
    import wide_field_rmw_pkg::*;
#(
    parameter int WIDTH   = 74,
    parameter int FIELD_W = 32,
    parameter int OFF_W   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   cur,
    input  mode_t              mode,
    input  logic [OFF_W-1:0]   offset,
    input  logic [FIELD_W-1:0] data,
    output logic [WIDTH-1:0]   next,
    output logic [WIDTH-1:0]   mask,
    output logic               in_range
);

    localparam logic [OFF_W:0] LIMIT = (OFF_W+1)'(WIDTH);

    logic [WIDTH-1:0] mask_raw;
    logic [WIDTH-1:0] d;

    assign in_range = {1'b0, offset} < LIMIT;
    assign mask_raw = WIDTH'(field_mask(32'(offset), WIDTH, FIELD_W));
    assign mask     = in_range ? mask_raw : '0;

    // Field bits shifted past the top of the register fall off here.
    assign d = WIDTH'({{WIDTH{1'b0}}, data} << offset) & mask;

    always_comb begin
        next = cur;
        if (in_range) begin
            case (mode)
                MODE_WRITE: next = (cur & ~mask) | d;
                MODE_XOR:   next = cur ^ d;
                MODE_OR:    next = cur | d;
                MODE_CLEAR: next = cur & ~d;
                default:    next = cur;
            endcase
        end
    end

endmodule

// File: rtl/wide_field_rmw_reg.sv
// Wide register updated by NCH chained field-RMW channels, with a pre-update slice read,
// a saturating update counter and sticky overlap / range-error flags.
module wide_field_rmw_reg
    import wide_field_rmw_pkg::*;
#(
    parameter int               WIDTH     = 74,
    parameter int               FIELD_W   = 32,
    parameter int               NCH       = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = 74'h2bcf02356897801abfe,
    parameter int               OFF_W     = $clog2(WIDTH),
    parameter int               CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         wr_valid,
    input  logic [2*NCH-1:0]       wr_mode,
    input  logic [OFF_W*NCH-1:0]   wr_offset,
    input  logic [FIELD_W*NCH-1:0] wr_data,
    input  logic [OFF_W-1:0]       rd_offset,
    output logic [FIELD_W-1:0]     rd_data,
    output logic [WIDTH-1:0]       q,
    output logic [CNT_W-1:0]       upd_cnt,
    output logic                   overlap_seen,
    output logic                   range_err
);

    localparam logic [OFF_W:0] LIMIT = (OFF_W+1)'(WIDTH);

    logic [WIDTH-1:0] chain     [NCH+1];
    logic [WIDTH-1:0] unit_next [NCH];
    logic [WIDTH-1:0] masks     [NCH];
    logic [NCH-1:0]   in_range;
    logic [NCH-1:0]   active;

    logic             overlap_now;
    logic             wr_err_now;
    logic             rd_in_range;
    logic [FIELD_W-1:0] rd_next;

    // Channels see each other's results in ascending index order.
    assign chain[0] = q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            field_rmw_unit #(
                .WIDTH   (WIDTH),
                .FIELD_W (FIELD_W),
                .OFF_W   (OFF_W)
            ) u_unit (
                .cur      (chain[gi]),
                .mode     (mode_t'(wr_mode[2*gi +: 2])),
                .offset   (wr_offset[OFF_W*gi +: OFF_W]),
                .data     (wr_data[FIELD_W*gi +: FIELD_W]),
                .next     (unit_next[gi]),
                .mask     (masks[gi]),
                .in_range (in_range[gi])
            );

            assign active[gi]   = wr_valid[gi] & in_range[gi];
            assign chain[gi+1]  = active[gi] ? unit_next[gi] : chain[gi];
        end
    endgenerate

    always_comb begin
        overlap_now = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            for (int j = i + 1; j < NCH; j++) begin
                if (active[i] && active[j] && (|(masks[i] & masks[j]))) begin
                    overlap_now = 1'b1;
                end
            end
        end
    end

    assign wr_err_now  = |(wr_valid & ~in_range);
    assign rd_in_range = {1'b0, rd_offset} < LIMIT;

    // Slice read of the pre-update value; bits above the register read as zero.
    assign rd_next = rd_in_range ? FIELD_W'({{FIELD_W{1'b0}}, q} >> rd_offset) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q            <= RESET_VAL;
            rd_data      <= '0;
            upd_cnt      <= '0;
            overlap_seen <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            q       <= chain[NCH];
            rd_data <= rd_next;
            if ((|active) && (upd_cnt != {CNT_W{1'b1}})) begin
                upd_cnt <= upd_cnt + CNT_W'(1);
            end
            if (overlap_now) begin
                overlap_seen <= 1'b1;
            end
            if (wr_err_now || !rd_in_range) begin
                range_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wide_field_rmw_reg.sv
// Directed bench for wide_field_rmw_reg: a per-bit reference model pushes expected state into a
// scoreboard queue at drive time; each cycle's DUT outputs are popped and checked one edge later.
module tb_wide_field_rmw_reg;
    import wide_field_rmw_pkg::*;

    localparam int WIDTH   = 74;
    localparam int FIELD_W = 32;
    localparam int NCH     = 2;
    localparam int OFF_W   = $clog2(WIDTH);
    localparam int CNT_W   = 16;
    localparam logic [WIDTH-1:0] RV = 74'h2bcf02356897801abfe;

    logic                   clk;
    logic                   rst_n;
    logic [NCH-1:0]         wr_valid;
    logic [2*NCH-1:0]       wr_mode;
    logic [OFF_W*NCH-1:0]   wr_offset;
    logic [FIELD_W*NCH-1:0] wr_data;
    logic [OFF_W-1:0]       rd_offset;
    logic [FIELD_W-1:0]     rd_data;
    logic [WIDTH-1:0]       q;
    logic [CNT_W-1:0]       upd_cnt;
    logic                   overlap_seen;
    logic                   range_err;

    logic [FIELD_W-1:0]     unused_rd_s;
    logic [WIDTH-1:0]       unused_q_s;
    logic [1:0]             cnt_s;
    logic                   unused_ovl_s;
    logic                   unused_rerr_s;

    wide_field_rmw_reg #(
        .WIDTH(WIDTH), .FIELD_W(FIELD_W), .NCH(NCH), .RESET_VAL(RV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_mode(wr_mode),
        .wr_offset(wr_offset), .wr_data(wr_data), .rd_offset(rd_offset),
        .rd_data(rd_data), .q(q), .upd_cnt(upd_cnt),
        .overlap_seen(overlap_seen), .range_err(range_err)
    );

    wide_field_rmw_reg #(
        .WIDTH(WIDTH), .FIELD_W(FIELD_W), .NCH(NCH), .RESET_VAL(RV), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_mode(wr_mode),
        .wr_offset(wr_offset), .wr_data(wr_data), .rd_offset(rd_offset),
        .rd_data(unused_rd_s), .q(unused_q_s), .upd_cnt(cnt_s),
        .overlap_seen(unused_ovl_s), .range_err(unused_rerr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   q;
        logic [FIELD_W-1:0] rd;
        logic [CNT_W-1:0]   cnt;
        logic [1:0]         cnt_sat;
        logic               ovl;
        logic               rerr;
    } exp_t;

    exp_t sb[$];

    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] m_cnt;
    logic [1:0]       m_sat;
    logic             m_ovl;
    logic             m_rerr;
    logic [WIDTH-1:0] rv_v;
    logic [WIDTH-1:0] snap;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(
        input logic rstn, input logic [1:0] v,
        input logic [1:0] m0, input logic [6:0] o0, input logic [31:0] d0,
        input logic [1:0] m1, input logic [6:0] o1, input logic [31:0] d1,
        input logic [6:0] ro, input string tag
    );
        exp_t e;
        logic [WIDTH-1:0] wq;
        logic [WIDTH-1:0] mk [2];
        logic [1:0]  md [2];
        logic [6:0]  of [2];
        logic [31:0] dd [2];
        logic any;
        int p;

        rst_n     = rstn;
        wr_valid  = v;
        wr_mode   = {m1, m0};
        wr_offset = {o1, o0};
        wr_data   = {d1, d0};
        rd_offset = ro;
        md[0] = m0; of[0] = o0; dd[0] = d0;
        md[1] = m1; of[1] = o1; dd[1] = d1;

        if (!rstn) begin
            e.q = RV; e.rd = '0; e.cnt = '0; e.cnt_sat = '0; e.ovl = 1'b0; e.rerr = 1'b0;
        end else begin
            wq = m_q; any = 1'b0; e.ovl = m_ovl; e.rerr = m_rerr;
            for (int ch = 0; ch < 2; ch++) begin
                mk[ch] = '0;
                if (v[ch]) begin
                    if (of[ch] >= WIDTH) begin
                        e.rerr = 1'b1;
                    end else begin
                        any = 1'b1;
                        for (int b = 0; b < FIELD_W; b++) begin
                            p = int'(of[ch]) + b;
                            if (p < WIDTH) begin
                                mk[ch][p] = 1'b1;
                                case (md[ch])
                                    2'd0:    wq[p] = dd[ch][b];
                                    2'd1:    wq[p] = wq[p] ^ dd[ch][b];
                                    2'd2:    wq[p] = wq[p] | dd[ch][b];
                                    default: wq[p] = wq[p] & ~dd[ch][b];
                                endcase
                            end
                        end
                    end
                end
            end
            if ((mk[0] & mk[1]) != '0) e.ovl = 1'b1;
            e.rd = '0;
            if (ro >= WIDTH) begin
                e.rerr = 1'b1;
            end else begin
                for (int b = 0; b < FIELD_W; b++) begin
                    p = int'(ro) + b;
                    if (p < WIDTH) e.rd[b] = m_q[p];
                end
            end
            e.q       = wq;
            e.cnt     = (any && m_cnt != '1) ? m_cnt + 1'b1 : m_cnt;
            e.cnt_sat = (any && m_sat != '1) ? m_sat + 1'b1 : m_sat;
        end

        m_q = e.q; m_cnt = e.cnt; m_sat = e.cnt_sat; m_ovl = e.ovl; m_rerr = e.rerr;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".q"},    128'(q),            128'(e.q));
        chk({tag, ".rd"},   128'(rd_data),      128'(e.rd));
        chk({tag, ".cnt"},  128'(upd_cnt),      128'(e.cnt));
        chk({tag, ".sat"},  128'(cnt_s),        128'(e.cnt_sat));
        chk({tag, ".ovl"},  128'(overlap_seen), 128'(e.ovl));
        chk({tag, ".rerr"}, 128'(range_err),    128'(e.rerr));
        $display("txn %s: q=%h rd=%h cnt=%0d sat=%0d ovl=%b rerr=%b",
                 tag, q, rd_data, upd_cnt, cnt_s, overlap_seen, range_err);
    endtask

    task automatic idle(input logic [6:0] ro, input string tag);
        step(1'b1, 2'b00, 2'd0, 7'd0, 32'h0, 2'd0, 7'd0, 32'h0, ro, tag);
    endtask

    task automatic rst(input string tag);
        step(1'b0, 2'b00, 2'd0, 7'd0, 32'h0, 2'd0, 7'd0, 32'h0, 7'd15, tag);
    endtask

    initial begin
        rv_v = RV;
        m_q = '0; m_cnt = '0; m_sat = '0; m_ovl = 1'b0; m_rerr = 1'b0;
        rst_n = 1'b0; wr_valid = '0; wr_mode = '0; wr_offset = '0; wr_data = '0; rd_offset = 7'd15;

        // Reset, then idle: pre-update slice at offset 15.
        rst("rst0");
        rst("rst1");
        chk("rst_q_lit", 128'(q), 128'(74'h2bcf02356897801abfe));
        for (int i = 0; i < 4; i++) idle(7'd15, "idle");
        chk("idle_rd_lit", 128'(rd_data), 128'(32'hAD12F003));

        // WRITE at 15; same-cycle read returns the old slice.
        step(1'b1, 2'b01, 2'd0, 7'd15, 32'h897abc16, 2'd0, 7'd0, 32'h0, 7'd15, "wr15");
        chk("wr15_q_lit",  128'(q),       128'(74'h2bcf02344bd5e0b2bfe));
        chk("wr15_rd_lit", 128'(rd_data), 128'(32'hAD12F003));
        chk("wr15_cnt",    128'(upd_cnt), 128'(16'd1));

        // XOR twice restores the reset value.
        rst("rst2");
        step(1'b1, 2'b01, 2'd1, 7'd15, 32'h1, 2'd0, 7'd0, 32'h0, 7'd15, "xor1");
        chk("xor1_q_lit", 128'(q), 128'(74'h2bcf023568978012bfe));
        step(1'b1, 2'b01, 2'd1, 7'd15, 32'h1, 2'd0, 7'd0, 32'h0, 7'd15, "xor2");
        chk("xor2_q_lit", 128'(q), 128'(rv_v));
        chk("xor2_cnt",   128'(upd_cnt), 128'(16'd2));

        // Two channels overlapping; ch1 wins on common bits.
        rst("rst3");
        step(1'b1, 2'b11, 2'd0, 7'd0, 32'h0, 2'd0, 7'd8, 32'hFFFFFFFF, 7'd0, "dual");
        chk("dual_lo",   128'(q[7:0]),   128'(8'h00));
        chk("dual_mid",  128'(q[39:8]),  128'(32'hFFFFFFFF));
        chk("dual_hi",   128'(q[73:40]), 128'(rv_v[73:40]));
        chk("dual_ovl",  128'(overlap_seen), 128'(1'b1));
        step(1'b1, 2'b11, 2'd0, 7'd0, 32'h12345678, 2'd1, 7'd0, 32'h0000FFFF, 7'd0, "wr_xor");
        chk("wr_xor_lo", 128'(q[31:0]), 128'(32'h1234A987));
        step(1'b1, 2'b11, 2'd2, 7'd40, 32'hF0F0F0F0, 2'd3, 7'd50, 32'h0000FFFF, 7'd36, "or_clr");
        step(1'b1, 2'b10, 2'd0, 7'd0, 32'h0, 2'd3, 7'd70, 32'hFFFFFFFF, 7'd44, "clr_top");

        // One channel in range, the other out of range: no overlap, range error.
        rst("rst4");
        step(1'b1, 2'b11, 2'd0, 7'd0, 32'hCAFEF00D, 2'd0, 7'd90, 32'hFFFFFFFF, 7'd0, "oor_ch1");
        chk("oor_ch1_ovl",  128'(overlap_seen), 128'(1'b0));
        chk("oor_ch1_rerr", 128'(range_err),    128'(1'b1));

        // Field straddling the top: excess bits dropped; offset past WIDTH ignored.
        rst("rst5");
        step(1'b1, 2'b01, 2'd0, 7'd60, 32'hFFFFFFFF, 2'd0, 7'd0, 32'h0, 7'd15, "top60");
        chk("top60_hi",   128'(q[73:60]),  128'(14'h3fff));
        chk("top60_lo",   128'(q[59:0]),   128'(rv_v[59:0]));
        chk("top60_rerr", 128'(range_err), 128'(1'b0));
        snap = q;
        step(1'b1, 2'b01, 2'd0, 7'd80, 32'hFFFFFFFF, 2'd0, 7'd0, 32'h0, 7'd15, "off80");
        chk("off80_q",    128'(q),         128'(snap));
        chk("off80_rerr", 128'(range_err), 128'(1'b1));
        chk("off80_cnt",  128'(upd_cnt),   128'(16'd1));
        idle(7'd60, "rd60");
        chk("rd60_lit", 128'(rd_data), 128'(32'h00003fff));
        idle(7'd100, "rd100");
        chk("rd100_lit", 128'(rd_data), 128'(32'h0));

        // Reset beats a same-cycle write.
        step(1'b0, 2'b01, 2'd0, 7'd0, 32'hFFFFFFFF, 2'd0, 7'd0, 32'h0, 7'd15, "rst_wr");
        chk("rst_wr_q",    128'(q),         128'(rv_v));
        chk("rst_wr_cnt",  128'(upd_cnt),   128'(16'd0));
        chk("rst_wr_rerr", 128'(range_err), 128'(1'b0));

        // Data-neutral updates still count; the 2-bit counter saturates.
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'b01, 2'd1, 7'd0, 32'h0, 2'd0, 7'd0, 32'h0, 7'd15, "cnt");
        chk("cnt_five", 128'(upd_cnt), 128'(16'd5));
        chk("cnt_sat3", 128'(cnt_s),   128'(2'd3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
